aes_block_packer: RTL and testbench
===================================

Name: aes_block_packer

Overview:
Upstream feeder for the AES-128 encrypt core. Accepts a byte stream with a valid/ready handshake and assembles the bytes into 128-bit blocks. Pads the final block of each message and presents blocks to the core over a valid/ready block interface. Byte 0 of a block (the first byte received) occupies bits [7:0], and byte i occupies bits [8*i+7:8*i], which matches the core's state byte ordering.

Parameters:
FILL_BYTE, 8'h00, byte used to fill the tail of a partial final block when padding is compiled out
CNT_W, 32, width of the running accepted-byte counter

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
in_data  in  8  input byte
in_valid  in  1  in_data valid
in_last  in  1  in_data is the final byte of the message
in_ready  out  1  packer can accept a byte this cycle
blk_data  out  128  assembled block
blk_valid  out  1  blk_data valid
blk_last  out  1  block is the final block of the message
blk_count  out  5  number of message data bytes in the block, 0..16
blk_ready  in  1  consumer accepts the block this cycle
byte_count  out  CNT_W  total bytes accepted since reset, wraps mod 2^CNT_W

Behaviour:
- Reset (clk edge with reset=1): state=FILL, idx=0, assembly reg=0, blk_data=0, blk_valid=0, blk_last=0, blk_count=0, byte_count=0. Reset mid-block or mid-PAD discards all partial and pending data. in_ready is 0 during reset.
- Byte accept: in_valid && in_ready. Block accept: blk_valid && blk_ready.
- out_free = !blk_valid || blk_ready.
- in_ready = (state==FILL) && out_free. This is combinational and does not depend on in_valid or in_last.
- Accepted byte: written to assembly byte idx; byte_count += 1.
- If the accepted byte is not in_last and idx<15: idx += 1, nothing emitted.
- Emit on idx==15 or in_last, at the same edge as the accept:
  - blk_data = assembled bytes 0..idx plus the completing byte; tail bytes idx+1..15 come from padding rules.
  - blk_valid=1, blk_count=idx+1, idx=0.
- blk_valid drops after a block accept unless a new block loads at the same edge. A simultaneous accept and load is legal and gives back-to-back blocks with no bubble.
- Latency: a completing byte accepted at edge N gives blk_valid=1 after edge N. Sustained throughput is one byte per cycle, i.e. one block per 16 cycles.
- blk_data, blk_last and blk_count hold stable while blk_valid && !blk_ready.
- States:
  - FILL: normal assembly.
  - PAD (padding build only): entered when in_last arrives with idx==15.
    - in_ready=0 in PAD.
    - When out_free: load a pad block with blk_last=1 and blk_count=0, then return to FILL.
- in_last on a non-final block position never produces an empty block except the PAD block.
- A zero-length message is impossible: in_last always accompanies a byte.

Optional Feature:
Macro AES_PKCS7_PAD_EN.
- Defined (PKCS#7 padding):
  - Partial final block with n bytes (n=1..15): tail bytes = 16-n, blk_last=1, blk_count=n.
  - Final byte at idx==15: that block goes out with blk_last=0 and blk_count=16. PAD state then emits a block of sixteen 8'h10 bytes with blk_last=1 and blk_count=0.
- Undefined (zero-fill):
  - Tail bytes = FILL_BYTE.
  - The block containing in_last has blk_last=1.
  - PAD state does not exist; a full final block is emitted with blk_last=1 and blk_count=16.

Test Plan:
1. 16 bytes 00..0f with in_last on 0f, blk_ready=1 → one block 128'h0f0e..0100.
   - blk_count=16, valid one cycle after 0f is accepted.
   - PKCS7: blk_last=0, followed next cycle by 128'h1010..10 with blk_last=1 and blk_count=0.
   - No PKCS7: blk_last=1, no second block.
2. 3 bytes aa,bb,cc, last on cc → bytes[2:0]=cc,bb,aa, blk_count=3, blk_last=1.
   - Tail = 13 bytes of 8'h0d (PKCS7) or FILL_BYTE (no PKCS7).
3. blk_ready held 0 for 10 cycles after a full block → in_ready=0 throughout; block stable.
   - After blk_ready=1, the next 16 bytes stream with no loss.
4. 48 bytes continuous, last on byte 47, blk_ready=1 → 3 blocks (plus the pad block in PKCS7), no bubbles.
   - byte_count=48.
5. reset=1 pulsed after 7 bytes of a block → all outputs 0, byte_count=0.
   - The next 16 bytes form a clean block starting at byte 0.
6. PKCS7: blk_ready=0 when in_last arrives at idx 15 → PAD waits; pad block appears only after the data block is accepted; in_ready=0 until the pad block loads.

Source files
------------

// File: rtl/aes_block_packer.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | aes_block_packer                                                       |
// | Packs a byte stream into 128-bit AES blocks and pads the final block.  |
// | Build option: AES_PKCS7_PAD_EN selects PKCS#7 padding (else zero-fill).|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module aes_block_packer #(
  parameter logic [7:0] FILL_BYTE = 8'h00,
  parameter int         CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [127:0]     blk_data,
  output logic             blk_valid,
  output logic             blk_last,
  output logic [4:0]       blk_count,
  input  logic             blk_ready,
  output logic [CNT_W-1:0] byte_count
);

`ifdef AES_PKCS7_PAD_EN
  localparam bit c_pad_en = 1'b1;
`else
  localparam bit c_pad_en = 1'b0;
`endif

  localparam logic [7:0]       c_pad_full = 8'h10;
  localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_PAD  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [127:0]       r_asm;
  logic [3:0]         r_idx;
  logic [127:0]       r_blk_data;
  logic               r_blk_valid;
  logic               r_blk_last;
  logic [4:0]         r_blk_count;
  logic [CNT_W-1:0]   r_byte_count;

  logic               w_out_free;
  logic               w_in_ready;
  logic               w_byte_acc;
  logic               w_blk_acc;
  logic               w_emit;
  logic               w_load_pad;
  logic               w_full_last;
  logic               w_last_out;
  logic [7:0]         w_tail;
  logic [127:0]       w_blk_build;

  assign w_out_free  = !r_blk_valid || blk_ready;
  assign w_in_ready  = (r_state == ST_FILL) && w_out_free && !reset;
  assign w_byte_acc  = in_valid && w_in_ready;
  assign w_blk_acc   = r_blk_valid && blk_ready;
  assign w_emit      = w_byte_acc && (in_last || (r_idx == 4'd15));
  assign w_full_last = in_last && (r_idx == 4'd15);
  // With PKCS#7 a full final block is not the last one: a pad block follows.
  assign w_last_out  = in_last && !(c_pad_en && w_full_last);
  assign w_tail      = c_pad_en ? (8'd15 - {4'd0, r_idx}) : FILL_BYTE;

  always_comb begin
    w_blk_build = '0;
    for (int i = 0; i < 16; i++) begin
      if (4'(i) < r_idx)
        w_blk_build[8*i +: 8] = r_asm[8*i +: 8];
      else if (4'(i) == r_idx)
        w_blk_build[8*i +: 8] = in_data;
      else
        w_blk_build[8*i +: 8] = w_tail;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_pad  = 1'b0;
    unique case (r_state)
      ST_FILL: begin
        if (c_pad_en && w_emit && w_full_last)
          w_state_nxt = ST_PAD;
      end
      ST_PAD: begin
        if (w_out_free) begin
          w_load_pad  = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_FILL;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_asm        <= '0;
      r_idx        <= '0;
      r_blk_data   <= '0;
      r_blk_valid  <= 1'b0;
      r_blk_last   <= 1'b0;
      r_blk_count  <= '0;
      r_byte_count <= '0;
    end else begin
      if (w_blk_acc)
        r_blk_valid <= 1'b0;
      if (w_load_pad) begin
        r_blk_data  <= {16{c_pad_full}};
        r_blk_valid <= 1'b1;
        r_blk_last  <= 1'b1;
        r_blk_count <= 5'd0;
      end
      if (w_byte_acc) begin
        r_asm[{r_idx, 3'b000} +: 8] <= in_data;
        r_byte_count                <= r_byte_count + c_cnt_one;
        if (w_emit) begin
          r_blk_data  <= w_blk_build;
          r_blk_valid <= 1'b1;
          r_blk_last  <= w_last_out;
          r_blk_count <= {1'b0, r_idx} + 5'd1;
          r_idx       <= 4'd0;
        end else begin
          r_idx <= r_idx + 4'd1;
        end
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign blk_data   = r_blk_data;
  assign blk_valid  = r_blk_valid;
  assign blk_last   = r_blk_last;
  assign blk_count  = r_blk_count;
  assign byte_count = r_byte_count;

endmodule
`default_nettype wire

// File: tb/tb_aes_block_packer.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | tb_aes_block_packer                                                    |
// | Scoreboard bench: byte-level reference model vs. emitted blocks.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_aes_block_packer;

  localparam logic [7:0] FILL = 8'h5C;
`ifdef AES_PKCS7_PAD_EN
  localparam bit PKCS = 1'b1;
`else
  localparam bit PKCS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         blk_last;
  logic [4:0]   blk_count;
  logic         blk_ready;
  logic [31:0]  byte_count;

  typedef struct {
    logic [127:0] d;
    logic         l;
    logic [4:0]   c;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mbuf[$];
  logic [31:0] mcnt;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          rand_mode = 1'b0;

  aes_block_packer #(.FILL_BYTE(FILL), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .blk_data(blk_data), .blk_valid(blk_valid), .blk_last(blk_last),
    .blk_count(blk_count), .blk_ready(blk_ready), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model: collect message bytes, cut at 16 or at the last byte.
  initial begin : monitor
    exp_t e;
    int   n;
    mcnt = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mbuf.delete();
        sb.delete();
        mcnt = '0;
      end else begin
        chk("byte_count", byte_count, mcnt);
        if (blk_valid && blk_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_block", 1'b1, 1'b0);
          end else begin
            e = sb.pop_front();
            chk("blk_data", blk_data, e.d);
            chk("blk_last", blk_last, e.l);
            chk("blk_count", blk_count, e.c);
          end
        end
        if (in_valid && in_ready) begin
          mcnt = mcnt + 1;
          mbuf.push_back(in_data);
          if (in_last || mbuf.size() == 16) begin
            n = mbuf.size();
            for (int i = 0; i < 16; i++)
              e.d[8*i +: 8] = (i < n) ? mbuf[i] : (PKCS ? 8'(16 - n) : FILL);
            e.c = 5'(n);
            e.l = in_last && !(PKCS && n == 16);
            sb.push_back(e);
            if (PKCS && in_last && n == 16) begin
              e.d = {16{8'h10}};
              e.l = 1'b1;
              e.c = 5'd0;
              sb.push_back(e);
            end
            mbuf.delete();
          end
        end
      end
    end
  end

  initial begin : rand_ready
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) blk_ready = ($urandom % 4) != 0;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b, input bit last, output int tries);
    bit acc;
    in_data  = b;
    in_last  = last;
    in_valid = 1'b1;
    tries    = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!acc && tries < 300);
    if (!acc) chk("send_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int k = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_empty", sb.size() == 0, 1'b1);
    chk("drain_idle", blk_valid, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_blk_valid", blk_valid, 1'b0);
    chk("rst_blk_data", blk_data, 128'd0);
    chk("rst_blk_last", blk_last, 1'b0);
    chk("rst_blk_count", blk_count, 5'd0);
    chk("rst_byte_count", byte_count, 32'd0);
  endtask

  initial begin : stim
    int t;
    int tot;
    int len;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; blk_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_in_reset", in_ready, 1'b0);
    do_reset();
    blk_ready = 1'b1;

    // 1: one full message of 00..0f
    for (int i = 0; i < 16; i++) send(8'(i), i == 15, t);
    chk("t1_latency_valid", blk_valid, 1'b1);
    chk("t1_count", blk_count, 5'd16);
    chk("t1_data", blk_data, 128'h0f0e0d0c0b0a09080706050403020100);
    chk("t1_last", blk_last, !PKCS);
`ifdef AES_PKCS7_PAD_EN
    @(posedge clk);
    #1;
    chk("t1_pad_last", blk_last, 1'b1);
    chk("t1_pad_count", blk_count, 5'd0);
    chk("t1_pad_data", blk_data, {16{8'h10}});
`endif
    drain();

    // 2: short message
    send(8'haa, 1'b0, t);
    send(8'hbb, 1'b0, t);
    send(8'hcc, 1'b1, t);
    chk("t2_low_bytes", blk_data[23:0], 24'hccbbaa);
    chk("t2_tail_byte", blk_data[127:120], PKCS ? 8'h0d : FILL);
    drain();

    // 3: consumer stall after a full block
    blk_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 1'b0, t);
    in_data = 8'h55; in_valid = 1'b1; in_last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t3_in_ready_stall", in_ready, 1'b0);
      chk("t3_blk_valid_hold", blk_valid, 1'b1);
      if (sb.size() > 0) chk("t3_blk_data_hold", blk_data, sb[0].d);
      @(posedge clk);
      #1;
    end
    blk_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(8'h55 + i), i == 15, t);
    drain();

    // 5: reset in the middle of a block
    for (int i = 0; i < 7; i++) send(8'(8'hE0 + i), 1'b0, t);
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(8'h90 + i), i == 15, t);
    drain();

    // 4: 48 bytes back to back
    do_reset();
    tot = 0;
    for (int i = 0; i < 48; i++) begin
      send(8'($urandom), i == 47, t);
      tot += t;
    end
    chk("t4_no_bubbles", tot, 48);
    chk("t4_byte_count", byte_count, 32'd48);
    drain();

`ifdef AES_PKCS7_PAD_EN
    // 6: full final block while the consumer stalls
    blk_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(8'h70 + i), i == 15, t);
    repeat (4) begin
      @(negedge clk);
      chk("t6_in_ready_pad", in_ready, 1'b0);
      chk("t6_data_blk_count", blk_count, 5'd16);
      chk("t6_data_blk_last", blk_last, 1'b0);
      @(posedge clk);
      #1;
    end
    blk_ready = 1'b1;
    @(negedge clk);
    chk("t6_in_ready_before_pad", in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("t6_pad_valid", blk_valid, 1'b1);
    chk("t6_pad_last", blk_last, 1'b1);
    chk("t6_pad_count", blk_count, 5'd0);
    drain();
`endif

    // Random messages with random gaps and consumer back-pressure
    rand_mode = 1'b1;
    for (int m = 0; m < 25; m++) begin
      len = $urandom_range(1, 40);
      for (int j = 0; j < len; j++) begin
        send(8'($urandom), j == len - 1, t);
        if ($urandom % 4 == 0) idle($urandom_range(1, 3));
      end
    end
    rand_mode = 1'b0;
    blk_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
